// File: rtl/ps2_rx_frame.sv
// PS/2-style serial frame receiver feeding a byte FIFO.
// Optional parity checking: define PS2_RX_PARITY_CHECK_EN.
module ps2_rx_frame #(
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic       pclk,
    input  logic       clear,
    input  logic       en,
    input  logic       kclk,
    input  logic       kdata,
    input  logic       full,
    output logic [7:0] wordOut,
    output logic       write,
    output logic       busy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [CNT_W-1:0] LP_TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_TMO_M1 = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_n;

    logic             r_kclk_s1;
    logic             r_kclk_s2;
    logic             r_kclk_d;
    logic             r_kdata_s1;
    logic             r_kdata_s2;

    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       r_word;
    logic             r_write;
    logic             r_perr;
    logic             r_ferr;
    logic             r_ovf;

    logic             w_fall;
    logic             w_bit;
    logic             w_timeout;
    logic             w_par_bad;
    logic             w_write_n;
    logic             w_perr_n;
    logic             w_ferr_n;
    logic             w_ovf_n;

    // Edges are ignored entirely while disabled.
    assign w_fall    = en & r_kclk_d & ~r_kclk_s2;
    assign w_bit     = r_kdata_s2;
    assign w_timeout = (r_state != S_IDLE) && !w_fall
                       && (r_cnt == LP_TMO_M1);

`ifdef PS2_RX_PARITY_CHECK_EN
    logic r_par;

    // Odd parity: data bits plus parity bit must XOR to 1.
    assign w_par_bad = ~(^{r_shift, r_par});

    // Capture the parity bit on its serial clock edge.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            r_par <= 1'b0;
        end else if (w_fall && r_state == S_PARITY) begin
            r_par <= w_bit;
        end
    end
`else
    // Parity bit still passes through PARITY but is not judged.
    assign w_par_bad = 1'b0;
`endif

    // Two-flop synchronizers plus a delay flop for edge detection.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            r_kclk_s1  <= 1'b0;
            r_kclk_s2  <= 1'b0;
            r_kclk_d   <= 1'b0;
            r_kdata_s1 <= 1'b0;
            r_kdata_s2 <= 1'b0;
        end else begin
            r_kclk_s1  <= kclk;
            r_kclk_s2  <= r_kclk_s1;
            r_kclk_d   <= r_kclk_s2;
            r_kdata_s1 <= kdata;
            r_kdata_s2 <= r_kdata_s1;
        end
    end

    // State register.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next state and one-cycle result pulses.
    always_comb begin
        w_state_n = r_state;
        w_write_n = 1'b0;
        w_perr_n  = 1'b0;
        w_ferr_n  = 1'b0;
        w_ovf_n   = 1'b0;
        if (!en) begin
            w_state_n = S_IDLE;
        end else if (w_timeout) begin
            w_ferr_n  = 1'b1;
            w_state_n = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_bit) begin
                        w_state_n = S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_idx == 3'd7) begin
                        w_state_n = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_state_n = S_STOP;
                end
                S_STOP: begin
                    w_state_n = S_IDLE;
                    if (!w_bit) begin
                        w_ferr_n = 1'b1;
                    end else if (w_par_bad) begin
                        w_perr_n = 1'b1;
                    end else if (full) begin
                        w_ovf_n = 1'b1;
                    end else begin
                        w_write_n = 1'b1;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    // Bit index and shift register, advanced on serial edges.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else if (w_fall) begin
            if (r_state == S_IDLE) begin
                r_idx <= 3'd0;
            end else if (r_state == S_DATA) begin
                r_shift[r_idx] <= w_bit;
                r_idx          <= r_idx + 3'd1;
            end
        end
    end

    // Inter-edge timeout counter; saturates instead of wrapping.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_fall) begin
            r_cnt <= '0;
        end else if (r_cnt != LP_TMO) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered outputs; byte register only moves on a good byte.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            r_word  <= 8'h00;
            r_write <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_write <= w_write_n;
            r_perr  <= w_perr_n;
            r_ferr  <= w_ferr_n;
            r_ovf   <= w_ovf_n;
            if (w_write_n) begin
                r_word <= r_shift;
            end
        end
    end

    assign wordOut = r_word;
    assign write   = r_write;
    assign perr    = r_perr;
    assign ferr    = r_ferr;
    assign ovf     = r_ovf;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

Serial frame receiver that sits directly upstream of the 4-word byte FIFO. It samples an external serial clock/data pair (PS/2-style framing: start, 8 data LSB-first, odd parity, stop) and assembles each byte. Each good byte is delivered to the FIFO as a one-cycle write strobe with the byte on `wordOut`. Framing, parity, timeout and FIFO-overflow errors are reported as one-cycle pulses.

## Interface
- `TIMEOUT`, 1000: pclk cycles allowed between serial clock falling edges inside a frame before abort.
- `CNT_W`, 16: width of the timeout counter; `TIMEOUT` < 2^`CNT_W`.

- `pclk`  in  1  system clock; all state changes on posedge.
- `clear`  in  1  reset, asynchronous, active-low.
- `en`  in  1  active-high enable; low forces IDLE.
- `kclk`  in  1  external serial clock, asynchronous to `pclk`.
- `kdata`  in  1  external serial data, asynchronous to `pclk`.
- `full`  in  1  FIFO full indication, driven from the FIFO `intr` output.
- `wordOut`  out  8  last good received byte, wired to FIFO `wordIn`.
- `write`  out  1  one-cycle write strobe to the FIFO.
- `busy`  out  1  high while a frame is in progress (state != IDLE).
- `perr`  out  1  one-cycle pulse on parity error.
- `ferr`  out  1  one-cycle pulse on bad stop bit or timeout.
- `ovf`  out  1  one-cycle pulse when a good byte is dropped because `full` was high.

## Operation
- `kclk` and `kdata` each pass through a 2-flop synchronizer. A third register on synchronized `kclk` detects falling edges, producing `fall` for one cycle. Synchronized `kdata` is sampled only when `fall` is high.
- States:
  - IDLE: on `fall` with sampled data 0 -> DATA with bit index 0. On `fall` with sampled data 1 -> stay in IDLE, no flag.
  - DATA: shift the sampled bit into the shift register at bit index. After bit 7 -> PARITY.
  - PARITY: store the sampled bit -> STOP.
  - STOP: evaluate the frame and return to IDLE.
- Stop evaluation, in priority order:
  - Stop bit 0: `ferr` pulse, byte discarded.
  - Parity fail (see Configuration): `perr` pulse, byte discarded.
  - `full` high: `ovf` pulse, byte discarded.
  - Otherwise: `wordOut` <= byte and `write` = 1 for exactly one cycle.
- Parity rule: data bits XOR parity bit must equal 1 (odd parity).
- `wordOut` changes only on a good byte and holds its value between frames.
- Timeout:
  - Counter clears on every `fall` and while in IDLE, and increments each pclk otherwise.
  - When it reaches `TIMEOUT`: `ferr` pulse, -> IDLE, partial byte discarded.
  - The counter saturates and never wraps.
- `en` low: -> IDLE next cycle and edges are ignored. A partial frame is aborted silently (no flag, no write).
- Reset (`clear` low, at any time including mid-frame): state IDLE, bit index 0, counter 0, shift register 0, synchronizers 0. Outputs: `wordOut`=8'h00, `write`=0, `busy`=0, `perr`=0, `ferr`=0, `ovf`=0.

## Timing
- Serial-edge latency: `fall` is asserted 3 pclk after the `kclk` falling edge reaches the pin.
- Write latency: `write` (or `perr`/`ferr`/`ovf`) asserts the pclk after the `fall` that samples the stop bit. `wordOut` is valid in the same cycle as `write`.
- At most one of `write`, `perr`, `ferr`, `ovf` is high in any cycle.
- `busy` rises the cycle after the start-bit `fall` and falls in the cycle the result pulse is asserted.
- `full` is sampled in the stop-evaluation cycle only.
- `kclk` low/high phases must each be >= 4 pclk.
- A start bit may arrive immediately after a stop bit; the IDLE->DATA transition is taken with no dead cycle.

## Configuration
- `PS2_RX_PARITY_CHECK_EN` defined: the parity check is active as described; a failed check pulses `perr` and drops the byte.
- Not defined: the parity bit is still clocked through the PARITY state but ignored. `perr` is tied 0, and bytes with bad parity are written normally.

## Test plan
- Frame for 0x1C, parity 0, stop 1, `full`=0 -> one `write` pulse, `wordOut`=8'h1C, no error pulses, `busy` low afterwards.
- Frame for 0xF0 with parity 0 (wrong) -> with macro: `perr` pulse, no `write`, `wordOut` unchanged. Without macro: `write` pulse, `wordOut`=8'hF0.
- Frame for 0x55 with stop bit 0 -> `ferr` pulse, no `write`. An immediately following good 0xAA frame -> `write`, `wordOut`=8'hAA.
- `full`=1 during a good 0x3C frame -> `ovf` pulse, no `write`, `wordOut` retains its prior value.
- Start plus 5 data bits, then `kclk` held high for `TIMEOUT`+5 pclk -> `ferr` pulse exactly `TIMEOUT` cycles after the last `fall`, then `busy`=0. The next full frame (0x12) is received correctly.
- `clear` pulsed low mid-frame (after 3 data bits), then a good 0x7E frame -> all outputs 0 during reset and no spurious `write`. After reset, one `write` with `wordOut`=8'h7E.
